// File: rtl/byte_gather_serializer.sv
// Captures eight byte lanes as two 32-bit words into a word buffer and replays
// them LSB-first as a valid/ready byte stream (In1 first, In8 last).
module byte_gather_serializer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          Start,
    input  logic [7:0]    In1,
    input  logic [7:0]    In2,
    input  logic [7:0]    In3,
    input  logic [7:0]    In4,
    input  logic [7:0]    In5,
    input  logic [7:0]    In6,
    input  logic [7:0]    In7,
    input  logic [7:0]    In8,
    output logic          Busy,
    output logic          Drop,
    output logic          Complete,
    output logic [AW:0]   Level,
    output logic [7:0]    Dout,
    output logic          Dout_Valid,
    input  logic          Dout_Ready
);

    typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;

    localparam logic [AW:0] SPACE_MAX = (AW+1)'(DEPTH - 2);

    state_t          state, state_next;
    logic [31:0]     reg1, reg2;
    logic [31:0]     mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [1:0]      idx;

    logic            accept, wr_en, drop_next, complete_next;
    logic [31:0]     wr_data;
    logic            load, pop;
    logic [31:0]     rd_word;
    logic [7:0]      rd_byte;

    assign Busy    = (state != IDLE);
    assign load    = (!Dout_Valid || Dout_Ready) && (Level != '0);
    assign pop     = load && (idx == 2'd3);
    assign rd_word = mem[rd_ptr];
    assign rd_byte = rd_word[{idx, 3'b000} +: 8];

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        wr_en         = 1'b0;
        wr_data       = reg1;
        drop_next     = 1'b0;
        complete_next = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if (Level <= SPACE_MAX) begin
                        accept     = 1'b1;
                        state_next = WR0;
                    end else begin
                        drop_next  = 1'b1;
                    end
                end
            end
            WR0: begin
                wr_en      = 1'b1;
                wr_data    = reg1;
                drop_next  = Start;
                state_next = WR1;
            end
            WR1: begin
                wr_en         = 1'b1;
                wr_data       = reg2;
                drop_next     = Start;
                complete_next = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state: FSM, pointers, occupancy and the output byte register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            Level      <= '0;
            idx        <= '0;
            Dout       <= 8'h00;
            Dout_Valid <= 1'b0;
            Drop       <= 1'b0;
            Complete   <= 1'b0;
        end else begin
            state    <= state_next;
            Drop     <= drop_next;
            Complete <= complete_next;
            if (wr_en)
                wr_ptr <= wr_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   Level <= Level + 1'b1;
                2'b01:   Level <= Level - 1'b1;
                default: Level <= Level;
            endcase
            if (load) begin
                Dout       <= rd_byte;
                Dout_Valid <= 1'b1;
                idx        <= idx + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
            end else if (Dout_Ready) begin
                Dout_Valid <= 1'b0;
            end
        end
    end

    // Data storage is not reset; a write coinciding with reset is suppressed
    always_ff @(posedge CLK) begin
        if (accept) begin
            reg1 <= {In4, In3, In2, In1};
            reg2 <= {In8, In7, In6, In5};
        end
        if (wr_en && !RESET)
            mem[wr_ptr] <= wr_data;
    end

endmodule

// File: tb/tb_byte_gather_serializer.sv
// Directed stimulus with a byte scoreboard: captures push expected bytes,
// a negedge monitor pops and compares on every Dout handshake.
module tb_byte_gather_serializer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        CLK = 1'b0;
    logic        RESET, Start, Dout_Ready;
    logic [7:0]  In1, In2, In3, In4, In5, In6, In7, In8;
    logic        Busy, Drop, Complete, Dout_Valid;
    logic [AW:0] Level;
    logic [7:0]  Dout;

    logic [7:0]  exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 CLK = ~CLK;

    byte_gather_serializer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start),
        .In1(In1), .In2(In2), .In3(In3), .In4(In4),
        .In5(In5), .In6(In6), .In7(In7), .In8(In8),
        .Busy(Busy), .Drop(Drop), .Complete(Complete), .Level(Level),
        .Dout(Dout), .Dout_Valid(Dout_Valid), .Dout_Ready(Dout_Ready)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A handshake seen at the negedge completes at the following posedge
    always @(negedge CLK) begin
        if (!RESET && Dout_Valid && Dout_Ready) begin
            if (exp_q.size() == 0)
                chk("stream_extra", int'(Dout), 256);
            else
                chk("stream", int'(Dout), int'(exp_q.pop_front()));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_lanes(input logic [63:0] l);
        {In8, In7, In6, In5, In4, In3, In2, In1} = l;
    endtask

    task automatic push_lanes(input logic [63:0] l);
        for (int i = 0; i < 8; i++)
            exp_q.push_back(l[8*i +: 8]);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"},     int'(Busy), 0);
        chk({tag, "_drop"},     int'(Drop), 0);
        chk({tag, "_complete"}, int'(Complete), 0);
        chk({tag, "_level"},    int'(Level), 0);
        chk({tag, "_dout"},     int'(Dout), 0);
        chk({tag, "_valid"},    int'(Dout_Valid), 0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0 && Level == '0 && !Dout_Valid)
                break;
            tick();
        end
        chk({tag, "_left"},  exp_q.size(), 0);
        chk({tag, "_level"}, int'(Level), 0);
        chk({tag, "_valid"}, int'(Dout_Valid), 0);
    endtask

    initial begin
        RESET = 1'b1; Start = 1'b0; Dout_Ready = 1'b0;
        set_lanes(64'h0);
        tick(); tick();
        chk_reset_outputs("rst");
        RESET = 1'b0;

        // Basic capture, full-rate drain
        Dout_Ready = 1'b1;
        set_lanes(64'h8877665544332211);
        push_lanes(64'h8877665544332211);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t1_busy", int'(Busy), 1);
        chk("t1_lvl0", int'(Level), 0);
        tick();
        chk("t1_lvl1", int'(Level), 1);
        chk("t1_nv", int'(Dout_Valid), 0);
        chk("t1_cmp0", int'(Complete), 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("t1_valid", int'(Dout_Valid), 1);
            chk("t1_dout", int'(Dout), 8'h11 * (k + 1));
            chk("t1_level", int'(Level), (k < 3) ? 2 : (k < 7) ? 1 : 0);
            chk("t1_complete", int'(Complete), (k == 0) ? 1 : 0);
        end
        tick();
        chk("t1_idle", int'(Dout_Valid), 0);
        wait_drain("t1");

        // Back-pressure holds the first byte
        set_lanes(64'h8877665544332211);
        push_lanes(64'h8877665544332211);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick();
        chk("t2_first", int'(Dout), 8'h11);
        Dout_Ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t2_hold", int'(Dout), 8'h11);
            chk("t2_hold_v", int'(Dout_Valid), 1);
        end
        Dout_Ready = 1'b1;
        wait_drain("t2");

        // Fill buffer, overflow Start, then drain across pointer wrap
        Dout_Ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            logic [63:0] l;
            for (int i = 0; i < 8; i++)
                l[8*i +: 8] = 8'h80 | 8'(c << 3) | 8'(i);
            set_lanes(l);
            push_lanes(l);
            Start = 1'b1;
            tick();
            Start = 1'b0;
            tick(); tick();
            chk("t3_fill", int'(Level), 2 * (c + 1));
        end
        set_lanes(64'hDEADBEEFCAFEF00D);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t3_drop", int'(Drop), 1);
        chk("t3_busy", int'(Busy), 0);
        chk("t3_full", int'(Level), 16);
        tick();
        chk("t3_drop_end", int'(Drop), 0);
        chk("t3_full2", int'(Level), 16);
        chk("t3_head", int'(Dout), 8'h80);
        chk("t3_head_v", int'(Dout_Valid), 1);
        Dout_Ready = 1'b1;
        wait_drain("t3");

        // Start held high for 6 cycles
        set_lanes(64'h0706050403020100);
        push_lanes(64'h0706050403020100);
        Start = 1'b1;
        tick();
        chk("t4_busy0", int'(Busy), 1);
        chk("t4_drop0", int'(Drop), 0);
        set_lanes(64'hF7F6F5F4F3F2F1F0);
        tick();
        chk("t4_drop1", int'(Drop), 1);
        set_lanes(64'hE7E6E5E4E3E2E1E0);
        tick();
        chk("t4_drop2", int'(Drop), 1);
        chk("t4_cmp", int'(Complete), 1);
        chk("t4_idle", int'(Busy), 0);
        set_lanes(64'h3736353433323130);
        push_lanes(64'h3736353433323130);
        tick();
        chk("t4_drop3", int'(Drop), 0);
        chk("t4_busy3", int'(Busy), 1);
        set_lanes(64'hD7D6D5D4D3D2D1D0);
        tick();
        chk("t4_drop4", int'(Drop), 1);
        tick();
        chk("t4_drop5", int'(Drop), 1);
        Start = 1'b0;
        tick();
        chk("t4_drop6", int'(Drop), 0);
        wait_drain("t4");

        // Reset during WR1
        set_lanes(64'h5555555555555555);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick();
        RESET = 1'b1;
        tick();
        chk_reset_outputs("t5a");
        RESET = 1'b0;
        // Reset mid-drain
        set_lanes(64'hB7B6B5B4B3B2B1B0);
        push_lanes(64'hB7B6B5B4B3B2B1B0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick(); tick();
        chk("t5_mid_v", int'(Dout_Valid), 1);
        chk("t5_mid_d", int'(Dout), 8'hB2);
        RESET = 1'b1;
        exp_q.delete();
        tick();
        chk_reset_outputs("t5b");
        RESET = 1'b0;
        set_lanes(64'hA7A6A5A4A3A2A1A0);
        push_lanes(64'hA7A6A5A4A3A2A1A0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        wait_drain("t5");

        // WR0 write coincides with a 4th-byte pop
        set_lanes(64'hC7C6C5C4C3C2C1C0);
        push_lanes(64'hC7C6C5C4C3C2C1C0);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        tick(); tick(); tick();
        chk("t6_lvl_a", int'(Level), 2);
        set_lanes(64'h4746454443424140);
        push_lanes(64'h4746454443424140);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("t6_lvl_b", int'(Level), 2);
        tick();
        chk("t6_same", int'(Level), 2);
        chk("t6_busy", int'(Busy), 1);
        tick();
        chk("t6_wr1", int'(Level), 3);
        wait_drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
